// File: rtl/bellek_kopyalayici.sv
// Block copy/fill engine: sole master of a 256x32 single-port synchronous memory.
// Optional running checksum of written words is built when BELLEK_KOPYALAYICI_CHECKSUM_EN is defined.
`timescale 1ns/1ps

module bellek_kopyalayici #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [AW:0]   len_i,
    input  logic [DW-1:0] fill_val_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] sum_o,
    output logic [AW-1:0] mem_a_o,
    output logic [DW-1:0] mem_d_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_q_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [AW-1:0] A_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] D_ZERO   = {DW{1'b0}};
    localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};

    state_t        state_q, state_d;
    logic          mode_q,  mode_d;
    logic [AW-1:0] src_q,   src_d;
    logic [AW-1:0] dst_q,   dst_d;
    logic [AW-1:0] last_q,  last_d;
    logic [AW-1:0] i_q,     i_d;
    logic [DW-1:0] fill_q,  fill_d;

    logic [AW-1:0] mem_a_s;
    logic [DW-1:0] mem_d_s;
    logic          mem_we_s;
    logic          accept_s;

    // Index of the final word; lengths of 256 and above all end at the top index.
    function automatic logic [AW-1:0] last_index(input logic [AW:0] len);
        logic [AW-1:0] r;
        if (len[AW]) begin
            r = {AW{1'b1}};
        end else begin
            r = len[AW-1:0] - A_ONE;
        end
        return r;
    endfunction

    assign accept_s = (state_q == ST_IDLE) && start_i;

    // Next-state, counter and operand-capture logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        last_d  = last_q;
        fill_d  = fill_q;
        i_d     = i_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    src_d  = src_i;
                    dst_d  = dst_i;
                    last_d = last_index(len_i);
                    fill_d = fill_val_i;
                    i_d    = A_ZERO;
                    if (len_i == LEN_ZERO) begin
                        state_d = ST_FIN;
                    end else if (mode_i) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                i_d = i_q + A_ONE;
                if (i_q == last_q) begin
                    state_d = ST_FIN;
                end else if (mode_q) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory pin decode; mem_q_i reaches mem_d only in a copy write cycle
    always_comb begin
        mem_a_s  = A_ZERO;
        mem_d_s  = D_ZERO;
        mem_we_s = 1'b0;
        case (state_q)
            ST_RD: begin
                mem_a_s = src_q + i_q;
            end
            ST_WR: begin
                mem_a_s  = dst_q + i_q;
                mem_we_s = 1'b1;
                if (mode_q) begin
                    mem_d_s = fill_q;
                end else begin
                    mem_d_s = mem_q_i;
                end
            end
            default: begin
                mem_a_s  = A_ZERO;
                mem_d_s  = D_ZERO;
                mem_we_s = 1'b0;
            end
        endcase
    end

    // State, counter and captured-operand registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            src_q   <= A_ZERO;
            dst_q   <= A_ZERO;
            last_q  <= A_ZERO;
            fill_q  <= D_ZERO;
            i_q     <= A_ZERO;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            last_q  <= last_d;
            fill_q  <= fill_d;
            i_q     <= i_d;
        end
    end

    assign mem_a_o  = mem_a_s;
    assign mem_d_o  = mem_d_s;
    assign mem_we_o = mem_we_s;
    assign busy_o   = (state_q == ST_RD) || (state_q == ST_WR);
    assign done_o   = (state_q == ST_FIN);

`ifdef BELLEK_KOPYALAYICI_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;

    // Checksum next value: cleared on acceptance, accumulates every written word
    always_comb begin
        sum_d = sum_q;
        if (accept_s) begin
            sum_d = D_ZERO;
        end else if (state_q == ST_WR) begin
            sum_d = sum_q + mem_d_s;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= D_ZERO;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`else
    assign sum_o = D_ZERO;
`endif

endmodule

// File: tb/tb_bellek_kopyalayici.sv
// Self-checking bench for bellek_kopyalayici: table of transfers, write scoreboard,
// plus hand sequences for reset abort and start-while-busy.
`timescale 1ns/1ps

module tb_bellek_kopyalayici;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [31:0] fill_val;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [7:0]  mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_q;

    bellek_kopyalayici #(.AW(8), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .src_i(src), .dst_i(dst), .len_i(len), .fill_val_i(fill_val),
        .busy_o(busy), .done_o(done), .sum_o(sum),
        .mem_a_o(mem_a), .mem_d_o(mem_d), .mem_we_o(mem_we), .mem_q_i(mem_q)
    );

    always #5 clk = ~clk;

    // memory model: write, or registered read that holds during writes
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_a] <= mem_d;
        else                 mem_q <= mem[mem_a];
    end

    typedef struct {
        logic        md;
        logic [7:0]  s;
        logic [7:0]  d;
        logic [8:0]  n;
        logic [31:0] fv;
        int          exp_done;
        int          exp_busy;
        int          exp_wr;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sbq[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  wr_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // write monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got a=%0h d=%0h, expected no write", mem_a, mem_d);
            end else begin
                wr_t w;
                w = sbq.pop_front();
                chk("wr_addr", {56'd0, mem_a}, {56'd0, w.a});
                chk("wr_data", {32'd0, mem_d}, {32'd0, w.d});
            end
        end
    end

    task automatic model(input logic md, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] n, input logic [31:0] fv, output logic [31:0] es);
        int cnt;
        cnt = (n > 9'd256) ? 256 : int'(n);
        es = 32'd0;
        for (int k = 0; k < cnt; k++) begin
            wr_t w;
            w.a = d + 8'(k);
            w.d = md ? fv : ref_mem[s + 8'(k)];
            ref_mem[w.a] = w.d;
            sbq.push_back(w);
            es = es + w.d;
        end
    endtask

    task automatic run_xfer(input vec_t v, input bit junk, input string tag);
        logic [31:0] es;
        int done_at;
        int busy_n;
        done_at = -1;
        busy_n  = 0;
        model(v.md, v.s, v.d, v.n, v.fv, es);
        wr_cnt   = 0;
        start    = 1'b1;
        mode     = v.md;
        src      = v.s;
        dst      = v.d;
        len      = v.n;
        fill_val = v.fv;
        @(posedge clk); #1;
        start    = 1'b0;
        src      = 8'($urandom);
        dst      = 8'($urandom);
        len      = 9'($urandom);
        fill_val = $urandom;
        for (int c = 1; c <= 600 && done_at < 0; c++) begin
            if (junk) begin
                start    = (c <= v.exp_done);
                mode     = ~v.md;
                len      = 9'd5;
                dst      = 8'h00;
                fill_val = 32'h2222_2222;
            end
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_at = c;
            if (done_at < 0) begin
                @(posedge clk); #1;
            end
        end
        if (done_at < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no done, expected done at cycle %0d", tag, v.exp_done);
        end
        chk({tag, "_done_cycle"}, 64'(done_at), 64'(v.exp_done));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(v.exp_busy));
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_idle_pins"}, {23'd0, mem_we, mem_a, mem_d}, 64'd0);
        chk({tag, "_wr_count"}, 64'(wr_cnt), 64'(v.exp_wr));
        chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
`ifdef BELLEK_KOPYALAYICI_CHECKSUM_EN
        chk({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
`else
        chk({tag, "_sum"}, {32'd0, sum}, 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        vec_t vj;
        int   nbad_img;
        logic [31:0] dummy;

        //              md    src    dst    len      fill          done busy wr
        vt[0] = '{1'b1, 8'h00, 8'h10, 9'd4,   32'hDEADBEEF, 5,   4,   4};
        vt[1] = '{1'b0, 8'h20, 8'h80, 9'd3,   32'h0,        7,   6,   3};
        vt[2] = '{1'b1, 8'h00, 8'hFE, 9'd4,   32'h5,        5,   4,   4};
        vt[3] = '{1'b1, 8'h00, 8'h70, 9'd0,   32'h99,       1,   0,   0};
        vt[4] = '{1'b0, 8'h30, 8'h31, 9'd4,   32'h0,        9,   8,   4};
        vt[5] = '{1'b0, 8'hFD, 8'h05, 9'd5,   32'h0,        11,  10,  5};
        vt[6] = '{1'b0, 8'h80, 8'h90, 9'd1,   32'h0,        3,   2,   1};
        vt[7] = '{1'b0, 8'h00, 8'h50, 9'd0,   32'h0,        1,   0,   0};
        vt[8] = '{1'b1, 8'h00, 8'h40, 9'h1FF, 32'hA5A50000, 257, 256, 256};

        for (int a = 0; a < 256; a++) begin
            mem[a]     <= 32'h1000_0000 | 32'(a);
            ref_mem[a]  = 32'h1000_0000 | 32'(a);
        end
        mem[8'h20] <= 32'd1;  ref_mem[8'h20] = 32'd1;
        mem[8'h21] <= 32'd2;  ref_mem[8'h21] = 32'd2;
        mem[8'h22] <= 32'd3;  ref_mem[8'h22] = 32'd3;

        rst = 1'b1; start = 1'b0; mode = 1'b0; src = 8'h0; dst = 8'h0;
        len = 9'h0; fill_val = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        chk("reset_pins", {23'd0, mem_we, mem_a, mem_d}, 64'd0);
        chk("reset_sum", {32'd0, sum}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            run_xfer(vt[v], 1'b0, $sformatf("v%0d", v));
            if (v == 0) begin
                chk("fill_0x10", {32'd0, mem[8'h10]}, 64'hDEADBEEF);
                chk("fill_0x13", {32'd0, mem[8'h13]}, 64'hDEADBEEF);
                chk("fill_0x0F_kept", {32'd0, mem[8'h0F]}, 64'h1000_000F);
                chk("fill_0x14_kept", {32'd0, mem[8'h14]}, 64'h1000_0014);
            end
            if (v == 1) begin
                chk("copy_0x80", {32'd0, mem[8'h80]}, 64'd1);
                chk("copy_0x81", {32'd0, mem[8'h81]}, 64'd2);
                chk("copy_0x82", {32'd0, mem[8'h82]}, 64'd3);
`ifdef BELLEK_KOPYALAYICI_CHECKSUM_EN
                chk("copy_sum", {32'd0, sum}, 64'd6);
`else
                chk("copy_sum", {32'd0, sum}, 64'd0);
`endif
            end
            if (v == 2) begin
                chk("wrap_0xFE", {32'd0, mem[8'hFE]}, 64'd5);
                chk("wrap_0xFF", {32'd0, mem[8'hFF]}, 64'd5);
                chk("wrap_0x00", {32'd0, mem[8'h00]}, 64'd5);
                chk("wrap_0x01", {32'd0, mem[8'h01]}, 64'd5);
                chk("wrap_0x02_kept", {32'd0, mem[8'h02]}, 64'h1000_0002);
            end
            nbad_img = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) nbad_img++;
            chk($sformatf("v%0d_mem_image", v), 64'(nbad_img), 64'd0);
        end

        // start held high while busy and through FIN with different operands
        vj = '{1'b1, 8'h00, 8'hC0, 9'd3, 32'h11, 4, 3, 3};
        run_xfer(vj, 1'b1, "busy_start");
        chk("busy_start_0xC2", {32'd0, mem[8'hC2]}, 64'h11);
        chk("busy_start_0xC3", {32'd0, mem[8'hC3]}, {32'd0, ref_mem[8'hC3]});
        chk("busy_start_0x00", {32'd0, mem[8'h00]}, {32'd0, ref_mem[8'h00]});

        // reset during the third write of an 8-word fill
        model(1'b1, 8'h00, 8'h60, 9'd3, 32'h77, dummy);
        wr_cnt = 0;
        start = 1'b1; mode = 1'b1; dst = 8'h60; len = 9'd8; fill_val = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort_pins", {23'd0, mem_we, mem_a, mem_d}, 64'd0);
        chk("abort_sum", {32'd0, sum}, 64'd0);
        rst = 1'b0;
        begin
            int done_n;
            done_n = 0;
            for (int c = 0; c < 12; c++) begin
                if (done === 1'b1) done_n++;
                @(posedge clk); #1;
            end
            chk("abort_no_done", 64'(done_n), 64'd0);
        end
        chk("abort_wr_count", 64'(wr_cnt), 64'd3);
        chk("abort_0x62", {32'd0, mem[8'h62]}, 64'h77);
        chk("abort_0x63_kept", {32'd0, mem[8'h63]}, {32'd0, ref_mem[8'h63]});
        chk("abort_sb_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
